// File: rtl/snake_pkg.sv
// Shared types for the snake steering controller: headings, turn codes and
// the wrap-around turn arithmetic used by every player lane.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        TURN_L = 1'b0,
        TURN_R = 1'b1
    } turn_t;

    function automatic dir_t apply_turn(input dir_t d, input turn_t t);
        logic [1:0] cur;
        logic [1:0] nxt;
        cur = d;
        nxt = (t == TURN_R) ? (cur + 2'd1) : (cur - 2'd1);
        return dir_t'(nxt);
    endfunction

    // Even-indexed snakes start heading right, odd-indexed start heading left.
    function automatic dir_t reset_dir(input int unsigned idx);
        logic [31:0] v;
        v = idx;
        return v[0] ? DIR_LEFT : DIR_RIGHT;
    endfunction

endpackage

// File: rtl/turn_fifo.sv
// Per-player pending-turn queue: show-ahead FIFO of 1-bit turn codes where a
// pop and a push in the same cycle both take effect even when full.
module turn_fifo #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0] mem_q, mem_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        dout     = mem_q[rd_ptr_q[AW-1:0]];
        do_pop   = pop & ~empty;
        // A full queue still accepts a push when the same cycle frees a slot.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Multi-player snake steering: debounced left/right buttons queue turns that
// are applied one per game tick to each player's heading.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int QUEUE_DEPTH  = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [N_PLAYERS-1:0]   left,
    input  logic [N_PLAYERS-1:0]   right,
    output logic [2*N_PLAYERS-1:0] dir,
    output logic [N_PLAYERS-1:0]   turned,
    output logic [N_PLAYERS-1:0]   overflow,
    input  logic                   clr_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        localparam dir_t RST_DIR = reset_dir(p);

        // Button index 0 is left, 1 is right, matching the turn_t code.
        logic [1:0]            raw;
        logic [1:0]            filt_q, filt_d;
        logic [1:0]            prev_q, prev_d;
        logic [1:0]            armed_q, armed_d;
        logic [1:0]            rise;
        logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
        logic                  push_q, push_d;
        logic                  push_turn_q, push_turn_d;
        logic                  fifo_pop, fifo_dout, fifo_full, fifo_empty;
        dir_t                  dir_q, dir_d;
        logic                  turned_q, turned_d;
        logic                  ovf_q, ovf_d;

        assign raw = {right[p], left[p]};

        always_comb begin
            filt_d  = filt_q;
            cnt_d   = '0;
            armed_d = armed_q;
            rise    = '0;
            for (int b = 0; b < 2; b++) begin
                if (raw[b] != filt_q[b]) begin
                    if (cnt_q[b] == CNT_LAST) begin
                        filt_d[b] = raw[b];
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                // A button held through reset must be seen released before it can fire.
                if (!filt_q[b] && !raw[b]) begin
                    armed_d[b] = 1'b1;
                end
                rise[b] = filt_q[b] & ~prev_q[b] & armed_q[b];
            end
            prev_d      = filt_q;
            push_d      = rise[0] ^ rise[1];
            push_turn_d = rise[1];

            fifo_pop = tick & ~fifo_empty;
            dir_d    = dir_q;
            if (fifo_pop) begin
                dir_d = apply_turn(dir_q, turn_t'(fifo_dout));
            end
            turned_d = fifo_pop;

            // A drop in the same cycle as a clear leaves the flag set.
            ovf_d = ovf_q;
            if (push_q && fifo_full && !fifo_pop) begin
                ovf_d = 1'b1;
            end else if (clr_overflow) begin
                ovf_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                filt_q      <= '0;
                prev_q      <= '0;
                armed_q     <= '0;
                cnt_q       <= '0;
                push_q      <= 1'b0;
                push_turn_q <= 1'b0;
                dir_q       <= RST_DIR;
                turned_q    <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                filt_q      <= filt_d;
                prev_q      <= prev_d;
                armed_q     <= armed_d;
                cnt_q       <= cnt_d;
                push_q      <= push_d;
                push_turn_q <= push_turn_d;
                dir_q       <= dir_d;
                turned_q    <= turned_d;
                ovf_q       <= ovf_d;
            end
        end

        turn_fifo #(
            .QUEUE_DEPTH(QUEUE_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push_q),
            .pop  (fifo_pop),
            .din  (push_turn_q),
            .dout (fifo_dout),
            .full (fifo_full),
            .empty(fifo_empty)
        );

        assign dir[2*p +: 2] = dir_q;
        assign turned[p]     = turned_q;
        assign overflow[p]   = ovf_q;
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random button/tick traffic
// compared against a queue-based model of the steering rules.
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    localparam int NP     = 2;
    localparam int QD     = 4;
    localparam int DB     = 16;
    localparam int SETTLE = DB + 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            tick = 1'b0;
    logic            clr_overflow = 1'b0;
    logic [NP-1:0]   left = '0;
    logic [NP-1:0]   right = '0;
    logic [2*NP-1:0] dir;
    logic [NP-1:0]   turned;
    logic [NP-1:0]   overflow;

    int checks = 0;
    int errors = 0;

    // Model: queue of turns (0=L, 1=R), heading as 0..3, sticky overflow,
    // last driven button levels and whether each button may fire.
    int mq[NP][$];
    int mdir[NP];
    bit movf[NP];
    bit mlvl_l[NP], mlvl_r[NP];
    bit marm_l[NP], marm_r[NP];

    snake_dir_ctrl #(
        .N_PLAYERS   (NP),
        .QUEUE_DEPTH (QD),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .left        (left),
        .right       (right),
        .dir         (dir),
        .turned      (turned),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            mdir[p]   = (p % 2 == 1) ? 3 : 1;
            movf[p]   = 1'b0;
            mlvl_l[p] = left[p];
            mlvl_r[p] = right[p];
            marm_l[p] = !left[p];
            marm_r[p] = !right[p];
        end
    endtask

    task automatic model_push(input int p, input int t);
        if (mq[p].size() == QD) movf[p] = 1'b1;
        else mq[p].push_back(t);
    endtask

    task automatic model_levels(input int p, input bit nl, input bit nr);
        bit rl, rr;
        rl = nl && !mlvl_l[p] && marm_l[p];
        rr = nr && !mlvl_r[p] && marm_r[p];
        if (!nl) marm_l[p] = 1'b1;
        if (!nr) marm_r[p] = 1'b1;
        mlvl_l[p] = nl;
        mlvl_r[p] = nr;
        if (rl != rr) model_push(p, rr ? 1 : 0);
    endtask

    task automatic apply_levels(input logic [NP-1:0] nl, input logic [NP-1:0] nr);
        left  = nl;
        right = nr;
        cyc(SETTLE);
        for (int p = 0; p < NP; p++) model_levels(p, nl[p], nr[p]);
    endtask

    task automatic press_r(input int p, input int times);
        for (int i = 0; i < times; i++) begin
            apply_levels(left, right | (NP'(1) << p));
            apply_levels(left, right & ~(NP'(1) << p));
        end
    endtask

    task automatic check_state(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s_dir%0d", tag, p), 32'(dir[2*p +: 2]), 32'(mdir[p]));
            chk($sformatf("%s_ovf%0d", tag, p), 32'(overflow[p]), 32'(movf[p]));
            chk($sformatf("%s_turned%0d", tag, p), 32'(turned[p]), 32'd0);
        end
    endtask

    task automatic model_pop(input int p, output bit did);
        int t;
        did = mq[p].size() > 0;
        if (did) begin
            t = mq[p].pop_front();
            mdir[p] = (t == 1) ? (mdir[p] + 1) % 4 : (mdir[p] + 3) % 4;
        end
    endtask

    task automatic do_tick(input string tag, input bit clr);
        bit did;
        tick = 1'b1;
        clr_overflow = clr;
        cyc(1);
        tick = 1'b0;
        clr_overflow = 1'b0;
        for (int p = 0; p < NP; p++) begin
            model_pop(p, did);
            if (clr) movf[p] = 1'b0;
            chk($sformatf("%s_pulse%0d", tag, p), 32'(turned[p]), 32'(did));
            chk($sformatf("%s_dir%0d", tag, p), 32'(dir[2*p +: 2]), 32'(mdir[p]));
            chk($sformatf("%s_ovf%0d", tag, p), 32'(overflow[p]), 32'(movf[p]));
        end
        cyc(1);
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s_after%0d", tag, p), 32'(turned[p]), 32'd0);
    endtask

    initial begin
        bit did;
        logic [NP-1:0] rl, rr;

        model_reset();
        cyc(2);
        check_state("in_reset");
        rst = 1'b1;
        cyc(2);
        check_state("post_reset");

        // Idle ticks after reset
        for (int i = 0; i < 3; i++) do_tick("idle", 1'b0);

        // Two right turns on player 0
        press_r(0, 2);
        check_state("two_queued");
        do_tick("r1", 1'b0);
        do_tick("r2", 1'b0);
        chk("p0_left_heading", 32'(dir[1:0]), 32'(DIR_LEFT));

        // Five presses into a depth-4 queue
        press_r(0, 5);
        chk("p0_ovf_set", 32'(overflow[0]), 32'd1);
        check_state("overfilled");
        for (int i = 0; i < 5; i++) do_tick("drain", 1'b0);
        do_tick("clear", 1'b1);

        // Short glitch is filtered out
        right[0] = 1'b1;
        cyc(DB / 2);
        right[0] = 1'b0;
        cyc(SETTLE);
        check_state("glitch");
        do_tick("glitch", 1'b0);

        // Simultaneous left+right rising on player 1
        apply_levels(2'b10, 2'b10);
        apply_levels(2'b00, 2'b00);
        do_tick("both", 1'b0);

        // Player 1 full queue: push lands in the same cycle as a tick
        press_r(1, 4);
        check_state("p1_full");
        right[1] = 1'b1;
        cyc(DB + 1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        model_pop(0, did);
        model_pop(1, did);
        model_push(1, 1);
        mlvl_r[1] = 1'b1;
        chk("coinc_pulse1", 32'(turned[1]), 32'd1);
        cyc(SETTLE);
        chk("coinc_ovf1", 32'(overflow[1]), 32'd0);
        check_state("coinc");
        apply_levels(2'b00, 2'b00);
        for (int i = 0; i < 5; i++) do_tick("coinc_drain", 1'b0);

        // Overflow event coincident with clear: flag stays set
        press_r(0, 4);
        right[0] = 1'b1;
        cyc(DB + 1);
        clr_overflow = 1'b1;
        cyc(1);
        clr_overflow = 1'b0;
        model_push(0, 1);
        mlvl_r[0] = 1'b1;
        chk("ovf_prio", 32'(overflow[0]), 32'd1);
        cyc(SETTLE);
        apply_levels(2'b00, 2'b00);
        do_tick("prio_clr", 1'b1);
        for (int i = 0; i < 4; i++) do_tick("prio_drain", 1'b0);

        // Mid-operation reset discards pending turns asynchronously
        press_r(0, 2);
        rst = 1'b0;
        #2;
        model_reset();
        check_state("async_rst");
        cyc(1);
        rst = 1'b1;
        cyc(2);
        do_tick("rst_t1", 1'b0);
        do_tick("rst_t2", 1'b0);

        // Button held through reset release does not fire until re-pressed
        right[0] = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        model_reset();
        cyc(SETTLE);
        do_tick("held", 1'b0);
        apply_levels(2'b00, 2'b00);
        press_r(0, 1);
        do_tick("held_rearm", 1'b0);

        // Random traffic
        for (int s = 0; s < 120; s++) begin
            rl = NP'($urandom);
            rr = NP'($urandom);
            apply_levels(rl, rr);
            check_state("rnd_lvl");
            if ($urandom_range(0, 1) == 1)
                do_tick("rnd_tick", $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
